// File: rtl/pipe_flow_ctrl.sv
// Parametrised pipeline flow controller: per-stage valid bits, stall/flush driven
// load enables, and saturating retire/bubble/flush performance counters.
module pipe_flow_ctrl #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic [NSTAGE-1:0] flush_req_i,
    input  logic              clr_cnt_i,
    output logic [NSTAGE-1:0] ena_o,
    output logic [NSTAGE-1:0] valid_o,
    output logic              retire_o,
    output logic              redirect_o,
    output logic [CNT_W-1:0]  retire_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [NSTAGE-1:0] valid_q, valid_d;
    logic [NSTAGE:0]   blk;
    logic [NSTAGE:0]   kin;
    logic [NSTAGE-1:0] khd;
    logic [NSTAGE-1:0] f;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Block and kill chains both ripple from the oldest stage towards IF.
    always_comb begin
        blk = '0;
        kin = '0;
        khd = '0;
        f   = flush_req_i & valid_q;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            blk[NSTAGE-1-k] = valid_q[NSTAGE-1-k] & (stall_req_i[NSTAGE-1-k] | blk[NSTAGE-k]);
            khd[NSTAGE-1-k] = kin[NSTAGE-k];
            kin[NSTAGE-1-k] = f[NSTAGE-1-k] | kin[NSTAGE-k];
        end
    end

    always_comb begin
        valid_d = '0;
        if (blk[0]) valid_d[0] = valid_q[0] & ~khd[0];
        else        valid_d[0] = in_valid_i & ~kin[0];
        for (int unsigned i = 1; i < NSTAGE; i++) begin
            if (blk[i]) valid_d[i] = valid_q[i] & ~khd[i];
            else        valid_d[i] = valid_q[i-1] & ~blk[i-1] & ~kin[i];
        end
    end

    assign ena_o      = ~blk[NSTAGE-1:0];
    assign valid_o    = valid_q;
    assign retire_o   = valid_q[NSTAGE-1] & ~stall_req_i[NSTAGE-1];
    assign redirect_o = |f;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (clr_cnt_i) begin
            retire_cnt_d = '0;
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            if (retire_o && retire_cnt_q != '1)   retire_cnt_d = retire_cnt_q + CNT_W'(1);
            if (!retire_o && bubble_cnt_q != '1)  bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            if (redirect_o && flush_cnt_q != '1)  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule
